// File: rtl/reg_ps.sv
// reg_ps: 4-bit parallel-in / serial-out frame transmitter, LSB first,
//   with an optional even-parity bit appended after the data bits.
// Ports: clk, rst (sync, active-high), pIn[3:0] data word, start request,
//   sOut serial line, busy (frame in flight), done (1-cycle completion pulse),
//   out1..out4 active-low 7-segment digits for shift-register bits 0..3.
// Optional feature: define REG_PS_PARITY_EN to add the parity bit and PARITY state.
module reg_ps #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pIn,
  input  logic       start,
  output logic       sOut,
  output logic       busy,
  output logic       done,
  output logic [6:0] out1,
  output logic [6:0] out2,
  output logic [6:0] out3,
  output logic [6:0] out4
);

`ifdef REG_PS_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_ONE  = 7'b1111001;

  state_t     state, state_n;
  logic [3:0] sreg, sreg_n;
  logic [1:0] cnt, cnt_n;

`ifdef REG_PS_PARITY_EN
  logic       par, par_n;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= 4'b0000;
      cnt   <= 2'd0;
`ifdef REG_PS_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
`ifdef REG_PS_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
`ifdef REG_PS_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sreg_n  = pIn;
          cnt_n   = 2'd0;
`ifdef REG_PS_PARITY_EN
          par_n   = ^pIn;
`endif
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        sreg_n = {1'b0, sreg[3:1]};
        // Last data bit: leave SHIFT and hold cnt so it never wraps.
        if (cnt == 2'd3) begin
`ifdef REG_PS_PARITY_EN
          state_n = PARITY;
`else
          state_n = DONE;
`endif
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
`ifdef REG_PS_PARITY_EN
      PARITY: state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    sOut = IDLE_LEVEL;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT: begin
        sOut = sreg[0];
        busy = 1'b1;
      end
`ifdef REG_PS_PARITY_EN
      PARITY: begin
        sOut = par;
        busy = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: sOut = IDLE_LEVEL;
    endcase
  end

  assign out1 = sreg[0] ? SEG_ONE : SEG_ZERO;
  assign out2 = sreg[1] ? SEG_ONE : SEG_ZERO;
  assign out3 = sreg[2] ? SEG_ONE : SEG_ZERO;
  assign out4 = sreg[3] ? SEG_ONE : SEG_ZERO;

endmodule

// File: tb/tb_reg_ps.sv
// tb_reg_ps: directed testbench for reg_ps with hand-computed expectations.
// Ports of the DUT are driven just after each rising edge and sampled 1 time
// unit after the edge, so each step() lands in the next "cycle".
module tb_reg_ps;
  logic       clk;
  logic       rst;
  logic [3:0] pIn;
  logic       start;
  logic       sOut;
  logic       busy;
  logic       done;
  logic [6:0] out1, out2, out3, out4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;

  int checks   = 0;
  int failures = 0;

  reg_ps dut (
    .clk   (clk),
    .rst   (rst),
    .pIn   (pIn),
    .start (start),
    .sOut  (sOut),
    .busy  (busy),
    .done  (done),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3),
    .out4  (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sout"}, sOut, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  task automatic check_segs(input string tag, input logic [3:0] bits);
    check({tag, "_out1"}, out1, bits[0] ? S1 : S0);
    check({tag, "_out2"}, out2, bits[1] ? S1 : S0);
    check({tag, "_out3"}, out3, bits[2] ? S1 : S0);
    check({tag, "_out4"}, out4, bits[3] ? S1 : S0);
  endtask

  // Checks four data cycles (current cycle = first data cycle) against the
  // expected LSB-first bit sequence; leaves the bench in the cycle after.
  task automatic check_frame(input string tag, input logic [3:0] bits);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_bit%0d", tag, k), sOut, bits[k]);
      check($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
      check($sformatf("%s_done%0d", tag, k), done, 1'b0);
      step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pIn   = 4'b0000;

    // Reset for 3 cycles, then idle
    repeat (3) step();
    check_idle("rst");
    check_segs("rst", 4'b0000);
    rst = 1'b0;
    step();
    check_idle("idle");
    check_segs("idle", 4'b0000);

    // Single frame 1011 -> 1,1,0,1
    pIn   = 4'b1011;
    start = 1'b1;
    step();
    start = 1'b0;
    pIn   = 4'b0000;
    check_segs("load1011", 4'b1011);
    check_frame("f1", 4'b1011);
`ifdef REG_PS_PARITY_EN
    check("f1_par", sOut, 1'b1);
    check("f1_par_busy", busy, 1'b1);
    check("f1_par_done", done, 1'b0);
    step();
`endif
    check("f1_done", done, 1'b1);
    check("f1_done_busy", busy, 1'b0);
    check("f1_done_sout", sOut, 1'b0);
    check_segs("f1_end", 4'b0000);
    step();
    check_idle("f1_after");

    // Back-to-back: start held, pIn changed mid-frame
    pIn   = 4'b1011;
    start = 1'b1;
    step();
    pIn = 4'b0110;
    check_frame("b1", 4'b1011);
`ifdef REG_PS_PARITY_EN
    check("b1_par", sOut, 1'b1);
    step();
`endif
    check("b1_done", done, 1'b1);
    step();
    start = 1'b0;
    check_frame("b2", 4'b0110);
`ifdef REG_PS_PARITY_EN
    check("b2_par", sOut, 1'b0);
    check("b2_par_busy", busy, 1'b1);
    step();
`endif
    check("b2_done", done, 1'b1);
    step();
    check_idle("b2_after");

    // Reset mid-frame, with start also high to test priority
    pIn   = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r_c1", sOut, 1'b1);
    step();
    check("r_c2", sOut, 1'b1);
    check("r_c2_busy", busy, 1'b1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_idle("r_abort");
    check_segs("r_abort", 4'b0000);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("r_nodone%0d", k), done, 1'b0);
      check($sformatf("r_nobusy%0d", k), busy, 1'b0);
    end

    // Display tracking with 1000
    pIn   = 4'b1000;
    start = 1'b1;
    step();
    start = 1'b0;
    check_segs("d_load", 4'b1000);
    step();
    check_segs("d_c2", 4'b0100);
    step();
    check_segs("d_c3", 4'b0010);
    step();
    check_segs("d_c4", 4'b0001);
    check("d_c4_sout", sOut, 1'b1);
    step();
    check_segs("d_end", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
